// File: rtl/mandel_pkg.sv
// Shared types and fixed formats for the Mandelbrot iteration ring.
// Coordinates are Q4.12 signed, |z|^2 is Q8.24 unsigned.
package mandel_pkg;

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned SUM_W  = 34;

  // |z|^2 == 4.0 in Q8.24
  localparam logic [SUM_W-1:0] ESCAPE_THR = 34'h4000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } inj_state_t;

  typedef struct packed {
    logic              valid;
    logic              frozen;
    logic [ADDR_W-1:0] addr;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{valid: 1'b0, frozen: 1'b0, addr: {ADDR_W{1'b0}}};

endpackage

// File: rtl/tag_ring.sv
// Shift register carrying each ring slot's tag alongside its token in the
// external pipe, so the tail tag meets the token returning on ret_*.
module tag_ring
  import mandel_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t head_i,
  output tag_t tail_o
);

  tag_t stage_q [DEPTH];

  // Advance every tag one slot per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= TAG_EMPTY;
      end
    end else begin
      stage_q[0] <= head_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_injector.sv
// Entry stage of the Mandelbrot ring: scans the frame, seeds free slots,
// recirculates or retires returning tokens. Option macro: INJ_PERF_CNT_EN.
module pixel_injector
  import mandel_pkg::*;
#(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      H_RES      = 640,
  parameter int unsigned      V_RES      = 480,
  parameter int unsigned      MAX_ITER   = 255,
  parameter int unsigned      PIPE_DEPTH = 8,
  parameter logic [WIDTH-1:0] X_START    = 16'hE000,
  parameter logic [WIDTH-1:0] Y_START    = 16'h1000,
  parameter logic [WIDTH-1:0] STEP       = 16'h0010
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  ret_x_i,
  input  logic [WIDTH-1:0]  ret_y_i,
  input  logic [WIDTH-1:0]  ret_c1_i,
  input  logic [WIDTH-1:0]  ret_c2_i,
  input  logic [DIV_W-1:0]  ret_div_i,
  input  logic              ret_no_op_i,
  input  logic [SUM_W-1:0]  ret_sum_i,
  output logic [WIDTH-1:0]  pipe_x_o,
  output logic [WIDTH-1:0]  pipe_y_o,
  output logic [WIDTH-1:0]  pipe_c1_o,
  output logic [WIDTH-1:0]  pipe_c2_o,
  output logic [DIV_W-1:0]  pipe_div_o,
  output logic              pipe_no_op_o,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DIV_W-1:0]  wr_data_o,
  output logic              busy_o,
  output logic              frame_done_o
`ifdef INJ_PERF_CNT_EN
  ,
  output logic [31:0]       frame_cycles_o
`endif
);

  localparam int unsigned      PX_W    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned      PY_W    = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned      OCC_W   = $clog2(PIPE_DEPTH + 2);
  localparam logic [PX_W-1:0]  PX_LAST = PX_W'(H_RES - 1);
  localparam logic [PY_W-1:0]  PY_LAST = PY_W'(V_RES - 1);
  localparam logic [DIV_W-1:0] DIV_CAP = DIV_W'(MAX_ITER);

  inj_state_t        state_q, state_d;
  logic [PX_W-1:0]   px_q, px_d;
  logic [PY_W-1:0]   py_q, py_d;
  logic [WIDTH-1:0]  c1_q, c1_d, c2_q, c2_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [WIDTH-1:0]  pipe_x_q, pipe_x_d, pipe_y_q, pipe_y_d;
  logic [WIDTH-1:0]  pipe_c1_q, pipe_c1_d, pipe_c2_q, pipe_c2_d;
  logic [DIV_W-1:0]  pipe_div_q, pipe_div_d;
  logic              pipe_no_op_q, pipe_no_op_d;
  tag_t              head_q, head_d, tail_s;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DIV_W-1:0]  wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              finished_s, free_s, inject_s, retire_s;

  // The tail tag is authoritative for slot occupancy; the pipe's own flag is redundant.
  logic unused_ret_no_op_s;
  assign unused_ret_no_op_s = ret_no_op_i;

  tag_ring #(.DEPTH(PIPE_DEPTH)) u_tag_ring (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .head_i (head_q),
    .tail_o (tail_s)
  );

  // A frozen token already qualified on an earlier lap and is only waiting for the writer.
  assign finished_s = tail_s.valid &
                      (tail_s.frozen | (ret_sum_i >= ESCAPE_THR) | (ret_div_i == DIV_CAP));

  // Slot decision for the returning tail, scan advance and frame sequencing.
  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    py_d         = py_q;
    c1_d         = c1_q;
    c2_d         = c2_q;
    addr_d       = addr_q;
    occ_d        = occ_q;
    pipe_x_d     = {WIDTH{1'b0}};
    pipe_y_d     = {WIDTH{1'b0}};
    pipe_c1_d    = {WIDTH{1'b0}};
    pipe_c2_d    = {WIDTH{1'b0}};
    pipe_div_d   = {DIV_W{1'b0}};
    pipe_no_op_d = 1'b1;
    head_d       = TAG_EMPTY;
    wr_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    free_s       = 1'b0;
    inject_s     = 1'b0;
    retire_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          px_d    = {PX_W{1'b0}};
          py_d    = {PY_W{1'b0}};
          c1_d    = X_START;
          c2_d    = Y_START;
          addr_d  = {ADDR_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN:   state_d = RUN;
      DRAIN: begin
        if (occ_q == {OCC_W{1'b0}}) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tail_s.valid && finished_s && wr_ready_i) begin
      retire_s   = 1'b1;
      free_s     = 1'b1;
      wr_valid_d = 1'b1;
      wr_addr_d  = tail_s.addr;
      wr_data_d  = ret_div_i;
    end else if (tail_s.valid) begin
      // Unfinished tokens iterate again; stalled finished ones circle untouched.
      pipe_x_d     = ret_x_i;
      pipe_y_d     = ret_y_i;
      pipe_c1_d    = ret_c1_i;
      pipe_c2_d    = ret_c2_i;
      pipe_div_d   = ret_div_i;
      pipe_no_op_d = finished_s;
      head_d       = '{valid: 1'b1, frozen: finished_s, addr: tail_s.addr};
    end else begin
      free_s = 1'b1;
    end

    if (free_s && (state_q == RUN)) begin
      inject_s     = 1'b1;
      pipe_c1_d    = c1_q;
      pipe_c2_d    = c2_q;
      pipe_no_op_d = 1'b0;
      head_d       = '{valid: 1'b1, frozen: 1'b0, addr: addr_q};
      addr_d       = addr_q + ADDR_W'(1);
      if (px_q == PX_LAST) begin
        px_d = {PX_W{1'b0}};
        py_d = py_q + PY_W'(1);
        c1_d = X_START;
        c2_d = c2_q - STEP;
        if (py_q == PY_LAST) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end else begin
        px_d = px_q + PX_W'(1);
        c1_d = c1_q + STEP;
      end
    end else begin
      inject_s = 1'b0;
    end

    case ({inject_s, retire_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, scan counters and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      px_q         <= {PX_W{1'b0}};
      py_q         <= {PY_W{1'b0}};
      c1_q         <= X_START;
      c2_q         <= Y_START;
      addr_q       <= {ADDR_W{1'b0}};
      occ_q        <= {OCC_W{1'b0}};
      pipe_x_q     <= {WIDTH{1'b0}};
      pipe_y_q     <= {WIDTH{1'b0}};
      pipe_c1_q    <= {WIDTH{1'b0}};
      pipe_c2_q    <= {WIDTH{1'b0}};
      pipe_div_q   <= {DIV_W{1'b0}};
      pipe_no_op_q <= 1'b1;
      head_q       <= TAG_EMPTY;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= {ADDR_W{1'b0}};
      wr_data_q    <= {DIV_W{1'b0}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      py_q         <= py_d;
      c1_q         <= c1_d;
      c2_q         <= c2_d;
      addr_q       <= addr_d;
      occ_q        <= occ_d;
      pipe_x_q     <= pipe_x_d;
      pipe_y_q     <= pipe_y_d;
      pipe_c1_q    <= pipe_c1_d;
      pipe_c2_q    <= pipe_c2_d;
      pipe_div_q   <= pipe_div_d;
      pipe_no_op_q <= pipe_no_op_d;
      head_q       <= head_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef INJ_PERF_CNT_EN
  logic [31:0] cycles_q, cycles_d;

  // Frame cycle counter: cleared by an accepted start, frozen once idle.
  always_comb begin
    if ((state_q == IDLE) && start_i) begin
      cycles_d = 32'd0;
    end else if (busy_q) begin
      cycles_d = cycles_q + 32'd1;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Frame cycle counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign frame_cycles_o = cycles_q;
`endif

  assign pipe_x_o     = pipe_x_q;
  assign pipe_y_o     = pipe_y_q;
  assign pipe_c1_o    = pipe_c1_q;
  assign pipe_c2_o    = pipe_c2_q;
  assign pipe_div_o   = pipe_div_q;
  assign pipe_no_op_o = pipe_no_op_q;
  assign wr_valid_o   = wr_valid_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_pixel_injector.sv
// Scoreboard bench for pixel_injector on a 4x2 frame with a 4-deep behavioural pipe.
`timescale 1ns/1ps
module tb_pixel_injector;

  localparam int unsigned H    = 4;
  localparam int unsigned V    = 2;
  localparam int unsigned D    = 4;
  localparam int unsigned NPIX = H * V;
  localparam logic [33:0] THR  = 34'h4000000;

  typedef struct packed {
    logic [15:0] x, y, c1, c2;
    logic [7:0]  div;
    logic        no_op;
    logic [33:0] sum;
  } tok_t;

  typedef struct {
    string  name;
    longint act;
    longint exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        wr_ready = 1'b1;
  logic [15:0] ret_x, ret_y, ret_c1, ret_c2;
  logic [7:0]  ret_div;
  logic        ret_no_op;
  logic [33:0] ret_sum;
  logic [15:0] pipe_x, pipe_y, pipe_c1, pipe_c2;
  logic [7:0]  pipe_div;
  logic        pipe_no_op;
  logic        wr_valid;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, frame_done;
`ifdef INJ_PERF_CNT_EN
  logic [31:0] frame_cycles;
`endif

  always #5 clk = ~clk;

  pixel_injector #(
    .WIDTH(16), .H_RES(H), .V_RES(V), .MAX_ITER(5), .PIPE_DEPTH(D),
    .X_START(16'hE000), .Y_START(16'h1000), .STEP(16'h0400)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .ret_x_i(ret_x), .ret_y_i(ret_y), .ret_c1_i(ret_c1), .ret_c2_i(ret_c2),
    .ret_div_i(ret_div), .ret_no_op_i(ret_no_op), .ret_sum_i(ret_sum),
    .pipe_x_o(pipe_x), .pipe_y_o(pipe_y), .pipe_c1_o(pipe_c1), .pipe_c2_o(pipe_c2),
    .pipe_div_o(pipe_div), .pipe_no_op_o(pipe_no_op),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .frame_done_o(frame_done)
`ifdef INJ_PERF_CNT_EN
    , .frame_cycles_o(frame_cycles)
`endif
  );

  // Behavioural pipe: D cycles of latency, div+1 unless no_op, |z|^2 chosen by mode.
  bit   div_mode = 1'b1;
  tok_t stage_q [D];

  function automatic tok_t model_step(input tok_t t, input bit mode);
    tok_t r = t;
    if (!t.no_op) r.div = t.div + 8'd1;
    if (mode) r.sum = (r.div >= 8'd1) ? THR : 34'h0;
    else      r.sum = THR - 34'd1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(D); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= model_step({pipe_x, pipe_y, pipe_c1, pipe_c2, pipe_div, pipe_no_op, 34'h0}, div_mode);
      for (int i = 1; i < int'(D); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign ret_x     = stage_q[D-1].x;
  assign ret_y     = stage_q[D-1].y;
  assign ret_c1    = stage_q[D-1].c1;
  assign ret_c2    = stage_q[D-1].c2;
  assign ret_div   = stage_q[D-1].div;
  assign ret_no_op = stage_q[D-1].no_op;
  assign ret_sum   = stage_q[D-1].sum;

  // Scoreboard state.
  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          done0 = 0;
  bit          strict = 1'b1;
  logic [26:0] exp_wr_q [$];
  logic [31:0] exp_inj_q [$];
  chk_t        chk_q [$];
  logic [15:0] c1_tab [H] = '{16'hE000, 16'hE400, 16'hE800, 16'hEC00};
  logic [15:0] c2_tab [V] = '{16'h1000, 16'h0C00};

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin : mon
    chk_t c;
    int   hit;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_cmp++;
      if (c.act != c.exp) begin
        n_err++;
        $display("FAIL %s: got %0h, want %0h", c.name, c.act, c.exp);
      end
    end
    if (rst_n) begin
      if (frame_done) done_cnt++;
      if (wr_valid) begin
        n_cmp++;
        hit = -1;
        if (strict) begin
          if (exp_wr_q.size() > 0 && exp_wr_q[0] == {wr_addr, wr_data}) hit = 0;
        end else begin
          for (int i = 0; i < exp_wr_q.size(); i++)
            if (hit < 0 && exp_wr_q[i] == {wr_addr, wr_data}) hit = i;
        end
        if (hit < 0) begin
          n_err++;
          if (exp_wr_q.size() > 0)
            $display("FAIL wr_result: got addr %0d data %0d, want addr %0d data %0d (%0d pending)",
                     wr_addr, wr_data, exp_wr_q[0][26:8], exp_wr_q[0][7:0], exp_wr_q.size());
          else
            $display("FAIL wr_result: got addr %0d data %0d, want no write", wr_addr, wr_data);
        end else begin
          exp_wr_q.delete(hit);
        end
      end
      if (!pipe_no_op && pipe_div == 8'd0) begin
        n_cmp++;
        if (exp_inj_q.size() == 0) begin
          n_err++;
          $display("FAIL inject: got c1 %h c2 %h, want no injection", pipe_c1, pipe_c2);
        end else begin
          if ({pipe_x, pipe_y, pipe_c1, pipe_c2} != {32'h0, exp_inj_q[0]}) begin
            n_err++;
            $display("FAIL inject: got x %h y %h c1 %h c2 %h, want x 0000 y 0000 c1 %h c2 %h",
                     pipe_x, pipe_y, pipe_c1, pipe_c2, exp_inj_q[0][31:16], exp_inj_q[0][15:0]);
          end
          void'(exp_inj_q.pop_front());
        end
      end
    end
  end

  task automatic push(input string n, input longint a, input longint e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input bit mode, input bit ordered, input logic [7:0] data);
    div_mode = mode;
    strict   = ordered;
    done0    = done_cnt;
    for (int p = 0; p < int'(NPIX); p++) begin
      exp_wr_q.push_back({19'(p), data});
      exp_inj_q.push_back({c1_tab[p % int'(H)], c2_tab[p / int'(H)]});
    end
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic finish_frame(input string n);
    bit ok = 1'b0;
`ifdef INJ_PERF_CNT_EN
    logic [31:0] fc;
`endif
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
    end
    if (!ok) push({n, " frame_done_timeout"}, 0, 1);
    cyc(3);
    @(negedge clk);
    push({n, " frame_done_count"}, done_cnt - done0, 1);
    push({n, " writes_outstanding"}, exp_wr_q.size(), 0);
    push({n, " injects_outstanding"}, exp_inj_q.size(), 0);
    push({n, " busy_after_done"}, busy, 0);
`ifdef INJ_PERF_CNT_EN
    fc = frame_cycles;
    push({n, " frame_cycles_nonzero"}, (fc != 32'd0), 1);
    cyc(5);
    @(negedge clk);
    push({n, " frame_cycles_stable"}, frame_cycles, fc);
`endif
    exp_wr_q.delete();
    exp_inj_q.delete();
  endtask

  initial begin
    int frozen_seen;
    // Reset values.
    @(negedge clk);
    push("reset pipe_no_op", pipe_no_op, 1);
    push("reset pipe_c1", pipe_c1, 0);
    push("reset wr_valid", wr_valid, 0);
    push("reset busy", busy, 0);
    push("reset frame_done", frame_done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1);

    // Reset mid-frame.
    begin_frame(1'b1, 1'b1, 8'd1);
    cyc(6);
    @(negedge clk);
    push("midrun busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    push("midrun_rst pipe_no_op", pipe_no_op, 1);
    push("midrun_rst wr_valid", wr_valid, 0);
    push("midrun_rst busy", busy, 0);
    exp_wr_q.delete();
    exp_inj_q.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Every token escapes at div=1 (|z|^2 exactly 4.0).
    begin_frame(1'b1, 1'b1, 8'd1);
    finish_frame("escape");

    // |z|^2 stays just below 4.0, tokens retire at the iteration cap.
    begin_frame(1'b0, 1'b1, 8'd5);
    finish_frame("maxiter");

    // Writer stalls for 10 cycles mid-frame.
    begin_frame(1'b1, 1'b0, 8'd1);
    cyc(2);
    wr_ready = 1'b0;
    frozen_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) push("stall wr_valid", wr_valid, 0);
      if (pipe_no_op && pipe_div == 8'd1) frozen_seen++;
    end
    @(posedge clk);
    #1 wr_ready = 1'b1;
    push("stall frozen_recirculated", (frozen_seen > 0), 1);
    finish_frame("stall");

    // start during RUN is ignored.
    begin_frame(1'b1, 1'b1, 8'd1);
    cyc(3);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    @(negedge clk);
    push("restart busy", busy, 1);
    finish_frame("restart");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
